// File: rtl/alu_issue_stage.sv
// Registered issue stage: decodes one MIPS instruction per cycle into an ALUControl
// code and two operands, with a two-entry main/skid buffer on a valid/ready handshake.
module alu_issue_stage (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Flush,
  input  logic        InValid,
  output logic        InReady,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic [4:0]  Shamt,
  input  logic [15:0] Imm,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [3:0]  ALUControl,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        Illegal,
  output logic [15:0] OpCount
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_NOR = 4'd4, ALU_XOR = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    alu_op_e     ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        illegal;
  } entry_t;

  entry_t main_q, skid_q, dec;
  logic   accept, drain;
  logic [15:0] count_q;

  logic [31:0] imm_sext, imm_zext, shamt_ext, rs_shift;
  assign imm_sext  = {{16{Imm[15]}}, Imm};
  assign imm_zext  = {16'h0000, Imm};
  assign shamt_ext = {27'b0, Shamt};
  assign rs_shift  = {27'b0, RsData[4:0]};

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.ctl     = ALU_ADD;
    dec.a       = RsData;
    dec.b       = RtData;
    dec.illegal = 1'b0;
    unique case (Opcode)
      6'b000000: begin
        case (Funct)
          6'b100000, 6'b100001: dec.ctl = ALU_ADD;
          6'b100010:            dec.ctl = ALU_SUB;
          6'b100100:            dec.ctl = ALU_AND;
          6'b100101:            dec.ctl = ALU_OR;
          6'b100111:            dec.ctl = ALU_NOR;
          6'b100110:            dec.ctl = ALU_XOR;
          6'b000000: begin dec.ctl = ALU_SLL; dec.a = RtData; dec.b = shamt_ext; end
          6'b000010: begin dec.ctl = ALU_SRL; dec.a = RtData; dec.b = shamt_ext; end
          6'b000100: begin dec.ctl = ALU_SLL; dec.a = RtData; dec.b = rs_shift;  end
          6'b000110: begin dec.ctl = ALU_SRL; dec.a = RtData; dec.b = rs_shift;  end
          default: begin
            dec.a       = '0;
            dec.b       = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      6'b001000, 6'b001001, 6'b100011, 6'b101011: dec.b = imm_sext;
      6'b001100: begin dec.ctl = ALU_AND; dec.b = imm_zext; end
      6'b001101: begin dec.ctl = ALU_OR;  dec.b = imm_zext; end
      6'b001110: begin dec.ctl = ALU_XOR; dec.b = imm_zext; end
      6'b000100, 6'b000101: dec.ctl = ALU_SUB;
      default: begin
        dec.a       = '0;
        dec.b       = '0;
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Ready depends only on registered skid state, never on OutReady.
  assign InReady = ~skid_q.valid;
  assign accept  = InValid & InReady;
  assign drain   = main_q.valid & OutReady;

  // NOTE: data fields are reset along with valid so outputs read zero out of reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      main_q  <= '0;
      skid_q  <= '0;
      count_q <= '0;
    end else if (Flush) begin
      main_q.valid <= 1'b0;
      skid_q.valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the old values.
      if (drain) begin
        if (skid_q.valid) begin
          main_q       <= skid_q;
          skid_q.valid <= 1'b0;
        end else if (accept) begin
          main_q <= dec;
        end else begin
          main_q.valid <= 1'b0;
        end
      end else if (accept) begin
        if (!main_q.valid) main_q <= dec;
        else               skid_q <= dec;
      end
      if (accept) count_q <= count_q + 16'd1;
    end
  end

  assign OutValid   = main_q.valid;
  assign ALUControl = main_q.ctl;
  assign A          = main_q.a;
  assign B          = main_q.b;
  assign Illegal    = main_q.illegal;
  assign OpCount    = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus backpressure,
// counter wrap, flush and asynchronous reset sequences.
module tb_alu_issue_stage;

  logic        Clk = 1'b0;
  logic        Rst_n, Flush, InValid, InReady, OutValid, OutReady, Illegal;
  logic [5:0]  Opcode, Funct;
  logic [4:0]  Shamt;
  logic [15:0] Imm, OpCount;
  logic [31:0] RsData, RtData, A, B;
  logic [3:0]  ALUControl;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_count = 16'd0;

  always #5 Clk = ~Clk;

  alu_issue_stage dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Opcode(Opcode), .Funct(Funct), .Shamt(Shamt), .Imm(Imm),
    .RsData(RsData), .RtData(RtData), .OutValid(OutValid), .OutReady(OutReady),
    .ALUControl(ALUControl), .A(A), .B(B), .Illegal(Illegal), .OpCount(OpCount)
  );

  typedef struct {
    string       name;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt);
    Opcode = op; Funct = fn; Shamt = sh; Imm = im; RsData = rs; RtData = rt;
  endtask

  task automatic add_vec(input string n, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [15:0] im, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [3:0] c, input logic [31:0] ea,
                         input logic [31:0] eb, input logic il);
    vec_t v;
    v.name = n; v.opcode = op; v.funct = fn; v.shamt = sh; v.imm = im;
    v.rs = rs; v.rt = rt; v.ctl = c; v.a = ea; v.b = eb; v.ill = il;
    vecs.push_back(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outvalid"}, {31'b0, OutValid}, 32'd0);
    check({tag, "_inready"},  {31'b0, InReady},  32'd1);
    check({tag, "_ctl"},      {28'b0, ALUControl}, 32'd0);
    check({tag, "_a"},        A, 32'd0);
    check({tag, "_b"},        B, 32'd0);
    check({tag, "_illegal"},  {31'b0, Illegal},  32'd0);
    check({tag, "_opcount"},  {16'b0, OpCount},  32'd0);
  endtask

  initial begin
    add_vec("add",    6'h00, 6'h20, 5'd3, 16'h1234, 32'd5,        32'd7,        4'd0, 32'd5,        32'd7,        1'b0);
    add_vec("addi",   6'h08, 6'h3F, 5'd0, 16'hFFFF, 32'd10,       32'd99,       4'd0, 32'd10,       32'hFFFFFFFF, 1'b0);
    add_vec("ori",    6'h0D, 6'h00, 5'd0, 16'hFFFF, 32'h12340000, 32'd1,        4'd3, 32'h12340000, 32'h0000FFFF, 1'b0);
    add_vec("sll",    6'h00, 6'h00, 5'd4, 16'h0000, 32'h0000ABCD, 32'd1,        4'd6, 32'd1,        32'd4,        1'b0);
    add_vec("srlv",   6'h00, 6'h06, 5'd9, 16'h0000, 32'h00000023, 32'h80,       4'd7, 32'h80,       32'd3,        1'b0);
    add_vec("addu",   6'h00, 6'h21, 5'd0, 16'h0000, 32'hFFFFFFFF, 32'd2,        4'd0, 32'hFFFFFFFF, 32'd2,        1'b0);
    add_vec("sub",    6'h00, 6'h22, 5'd0, 16'h0000, 32'd9,        32'd3,        4'd1, 32'd9,        32'd3,        1'b0);
    add_vec("and",    6'h00, 6'h24, 5'd0, 16'h0000, 32'hF0F0,     32'hFF00,     4'd2, 32'hF0F0,     32'hFF00,     1'b0);
    add_vec("or",     6'h00, 6'h25, 5'd0, 16'h0000, 32'h1,        32'h2,        4'd3, 32'h1,        32'h2,        1'b0);
    add_vec("nor",    6'h00, 6'h27, 5'd0, 16'h0000, 32'h11,       32'h22,       4'd4, 32'h11,       32'h22,       1'b0);
    add_vec("xor",    6'h00, 6'h26, 5'd0, 16'h0000, 32'h33,       32'h44,       4'd5, 32'h33,       32'h44,       1'b0);
    add_vec("srl",    6'h00, 6'h02, 5'd31, 16'h0000, 32'd8,       32'hF0000000, 4'd7, 32'hF0000000, 32'd31,       1'b0);
    add_vec("sllv",   6'h00, 6'h04, 5'd2, 16'h0000, 32'hFFFFFFE1, 32'h55,       4'd6, 32'h55,       32'd1,        1'b0);
    add_vec("addiu",  6'h09, 6'h00, 5'd0, 16'h0004, 32'd100,      32'd0,        4'd0, 32'd100,      32'd4,        1'b0);
    add_vec("lw",     6'h23, 6'h00, 5'd0, 16'h8000, 32'h100,      32'd0,        4'd0, 32'h100,      32'hFFFF8000, 1'b0);
    add_vec("sw",     6'h2B, 6'h00, 5'd0, 16'h7FFF, 32'h200,      32'd0,        4'd0, 32'h200,      32'h00007FFF, 1'b0);
    add_vec("andi",   6'h0C, 6'h00, 5'd0, 16'h8001, 32'hFFFFFFFF, 32'd0,        4'd2, 32'hFFFFFFFF, 32'h00008001, 1'b0);
    add_vec("xori",   6'h0E, 6'h00, 5'd0, 16'hF00F, 32'h7,        32'd0,        4'd5, 32'h7,        32'h0000F00F, 1'b0);
    add_vec("beq",    6'h04, 6'h00, 5'd0, 16'h0010, 32'd4,        32'd4,        4'd1, 32'd4,        32'd4,        1'b0);
    add_vec("bne",    6'h05, 6'h00, 5'd0, 16'hFFF0, 32'd6,        32'd8,        4'd1, 32'd6,        32'd8,        1'b0);
    add_vec("op3f",   6'h3F, 6'h20, 5'd1, 16'h1111, 32'd5,        32'd6,        4'd0, 32'd0,        32'd0,        1'b1);
    add_vec("rbad",   6'h00, 6'h03, 5'd2, 16'h0000, 32'd5,        32'd6,        4'd0, 32'd0,        32'd0,        1'b1);

    Rst_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    drive(6'h00, 6'h00, 5'd0, 16'h0, 32'd0, 32'd0);
    #12;
    check_reset_outputs("reset");
    Rst_n = 1'b1;
    step();

    // Decode table, back to back with the consumer always ready.
    foreach (vecs[i]) begin
      drive(vecs[i].opcode, vecs[i].funct, vecs[i].shamt, vecs[i].imm, vecs[i].rs, vecs[i].rt);
      InValid = 1'b1;
      step();
      exp_count++;
      check({vecs[i].name, "_valid"},   {31'b0, OutValid},   32'd1);
      check({vecs[i].name, "_ctl"},     {28'b0, ALUControl}, {28'b0, vecs[i].ctl});
      check({vecs[i].name, "_a"},       A, vecs[i].a);
      check({vecs[i].name, "_b"},       B, vecs[i].b);
      check({vecs[i].name, "_illegal"}, {31'b0, Illegal},    {31'b0, vecs[i].ill});
      check({vecs[i].name, "_count"},   {16'b0, OpCount},    {16'b0, exp_count});
    end
    InValid = 1'b0;
    step();
    check("idle_outvalid", {31'b0, OutValid}, 32'd0);

    // Backpressure: X into main, Y into skid, Z must wait.
    OutReady = 1'b0;
    InValid  = 1'b1;
    drive(6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd1);
    step(); exp_count++;
    check("bp_x_valid",  {31'b0, OutValid}, 32'd1);
    check("bp_x_ready",  {31'b0, InReady},  32'd1);
    drive(6'h00, 6'h22, 5'd0, 16'h0, 32'd2, 32'd2);
    step(); exp_count++;
    check("bp_y_ready",  {31'b0, InReady},  32'd0);
    check("bp_hold_a",   A, 32'd1);
    drive(6'h00, 6'h24, 5'd0, 16'h0, 32'd3, 32'd3);
    step();
    check("bp_z_blocked_count", {16'b0, OpCount}, {16'b0, exp_count});
    check("bp_hold_ctl", {28'b0, ALUControl}, 32'd0);
    check("bp_hold_a2",  A, 32'd1);
    OutReady = 1'b1;
    step();
    check("bp_y_a",      A, 32'd2);
    check("bp_y_ctl",    {28'b0, ALUControl}, 32'd1);
    check("bp_y_inready", {31'b0, InReady}, 32'd1);
    check("bp_y_count",  {16'b0, OpCount}, {16'b0, exp_count});
    step(); exp_count++;
    check("bp_z_a",      A, 32'd3);
    check("bp_z_ctl",    {28'b0, ALUControl}, 32'd2);
    check("bp_z_count",  {16'b0, OpCount}, {16'b0, exp_count});
    InValid = 1'b0;
    step();
    check("bp_drained",  {31'b0, OutValid}, 32'd0);

    // Bring the counter to 0xFFFF, then one more accept must wrap it.
    drive(6'h3F, 6'h00, 5'd0, 16'h0, 32'd0, 32'd0);
    InValid = 1'b1;
    for (int k = 0; k < int'(16'hFFFF - exp_count); k++) step();
    exp_count = 16'hFFFF;
    check("count_ffff", {16'b0, OpCount}, 32'h0000FFFF);
    step(); exp_count = exp_count + 16'd1;
    check("count_wrap", {16'b0, OpCount}, {16'b0, exp_count});
    check("wrap_illegal", {31'b0, Illegal}, 32'd1);
    InValid = 1'b0;
    step();

    // Flush with both entries full and a simultaneous offer.
    OutReady = 1'b0;
    InValid  = 1'b1;
    drive(6'h00, 6'h25, 5'd0, 16'h0, 32'd4, 32'd5);
    step(); step(); exp_count = exp_count + 16'd2;
    check("pre_flush_ready", {31'b0, InReady}, 32'd0);
    Flush = 1'b1;
    step();
    Flush = 1'b0; InValid = 1'b0;
    check("flush_outvalid", {31'b0, OutValid}, 32'd0);
    check("flush_inready",  {31'b0, InReady},  32'd1);
    check("flush_count",    {16'b0, OpCount},  {16'b0, exp_count});

    // Asynchronous reset while both entries hold data.
    InValid = 1'b1;
    drive(6'h00, 6'h22, 5'd0, 16'h0, 32'd9, 32'd3);
    step(); step();
    check("pre_rst_valid", {31'b0, OutValid}, 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    InValid = 1'b0;
    #3 Rst_n = 1'b1;
    step();
    check("post_rst_outvalid", {31'b0, OutValid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
